// File: rtl/vend_pkg.sv
// Shared types and codes for the vending back-end: FSM states, change codes
// and fault codes (the change codes are shared with the coin/price FSM).
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROD_PULSE,
    ST_PROD_WAIT,
    ST_COIN_PULSE,
    ST_COIN_WAIT,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam logic [1:0] CHG_NONE = 2'd0;
  localparam logic [1:0] CHG_5    = 2'd1;
  localparam logic [1:0] CHG_10   = 2'd2;

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_PROD = 2'd1;
  localparam logic [1:0] FLT_COIN = 2'd2;

  // Code 3 is reserved and behaves like "no change".
  function automatic logic chg_valid(input logic [1:0] code);
    return (code == CHG_5) || (code == CHG_10);
  endfunction

endpackage

// File: rtl/vend_sense_sync.sv
// Brings an asynchronous drop sensor into the clk domain and produces a
// one-cycle strobe on each rising edge.
module vend_sense_sync (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic strobe
);

  // Bits [1:0] are the synchronizer, bit [2] is the edge-detect history.
  logic [2:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= 3'b000;
    end else begin
      shift <= {shift[1:0], sense};
    end
  end

  assign strobe = shift[1] & ~shift[2];

endmodule

// File: rtl/vend_dispenser.sv
// Actuator controller: pulses the product motor and/or one coin hopper per
// request and waits for the matching drop sensor, faulting on timeout.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_vend,
  input  logic [1:0] req_change,
  output logic       prod_drive,
  output logic       coin5_drive,
  output logic       coin10_drive,
  input  logic       prod_sense,
  input  logic       coin_sense,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n, after_prod;
  logic [CW-1:0] cnt, cnt_n;
  logic          seen, seen_n;
  logic          vend_q, vend_n;
  logic [1:0]    chg_q, chg_n;
  logic [1:0]    fcode_q, fcode_n;
  logic          prod_strobe, coin_strobe;

  vend_sense_sync u_prod_sync (
    .clk    (clk),
    .rst    (rst),
    .sense  (prod_sense),
    .strobe (prod_strobe)
  );

  vend_sense_sync u_coin_sync (
    .clk    (clk),
    .rst    (rst),
    .sense  (coin_sense),
    .strobe (coin_strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      seen    <= 1'b0;
      vend_q  <= 1'b0;
      chg_q   <= CHG_NONE;
      fcode_q <= FLT_NONE;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      seen    <= seen_n;
      vend_q  <= vend_n;
      chg_q   <= chg_n;
      fcode_q <= fcode_n;
    end
  end

  // Every stage exit clears cnt/seen so the next pulse state starts fresh;
  // a strobe arriving in the last pulse cycle still counts as seen.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    seen_n     = seen;
    vend_n     = vend_q;
    chg_n      = chg_q;
    fcode_n    = fcode_q;
    after_prod = chg_valid(chg_q) ? ST_COIN_PULSE : ST_DONE;
    case (state)
      ST_IDLE: begin
        cnt_n  = '0;
        seen_n = 1'b0;
        if (req_valid) begin
          vend_n = req_vend;
          chg_n  = chg_valid(req_change) ? req_change : CHG_NONE;
          if (req_vend)                    state_n = ST_PROD_PULSE;
          else if (chg_valid(req_change))  state_n = ST_COIN_PULSE;
          else                             state_n = ST_DONE;
        end
      end
      ST_PROD_PULSE: begin
        seen_n = seen | prod_strobe;
        if (cnt == PULSE_LAST) begin
          if (seen | prod_strobe) begin
            state_n = after_prod;
            cnt_n   = '0;
            seen_n  = 1'b0;
          end else begin
            state_n = ST_PROD_WAIT;
          end
        end
      end
      ST_PROD_WAIT: begin
        if (prod_strobe) begin
          state_n = after_prod;
          cnt_n   = '0;
          seen_n  = 1'b0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n = ST_FAULT;
          fcode_n = FLT_PROD;
        end
      end
      ST_COIN_PULSE: begin
        seen_n = seen | coin_strobe;
        if (cnt == PULSE_LAST) begin
          if (seen | coin_strobe) begin
            state_n = ST_DONE;
            cnt_n   = '0;
            seen_n  = 1'b0;
          end else begin
            state_n = ST_COIN_WAIT;
          end
        end
      end
      ST_COIN_WAIT: begin
        if (coin_strobe) begin
          state_n = ST_DONE;
          cnt_n   = '0;
          seen_n  = 1'b0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n = ST_FAULT;
          fcode_n = FLT_COIN;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      ST_FAULT: begin
        cnt_n = cnt;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign req_ready    = (state == ST_IDLE);
  assign prod_drive   = (state == ST_PROD_PULSE) && vend_q;
  assign coin5_drive  = (state == ST_COIN_PULSE) && (chg_q == CHG_5);
  assign coin10_drive = (state == ST_COIN_PULSE) && (chg_q == CHG_10);
  assign done         = (state == ST_DONE);
  assign fault        = (state == ST_FAULT);
  assign fault_code   = fcode_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Randomized self-checking bench for vend_dispenser; expected outputs come from
// a per-request timeline computed from stage start times and sensor delays.
module tb_vend_dispenser;

  localparam int P = 4;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_vend;
  logic [1:0] req_change;
  logic       prod_drive;
  logic       coin5_drive;
  logic       coin10_drive;
  logic       prod_sense;
  logic       coin_sense;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_vend     (req_vend),
    .req_change   (req_change),
    .prod_drive   (prod_drive),
    .coin5_drive  (coin5_drive),
    .coin10_drive (coin10_drive),
    .prod_sense   (prod_sense),
    .coin_sense   (coin_sense),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  // Output bundle: {ready, prod, coin5, coin10, done, fault, fault_code}
  function automatic logic [7:0] outs();
    return {req_ready, prod_drive, coin5_drive, coin10_drive, done, fault, fault_code};
  endfunction

  localparam logic [7:0] IDLE_OUTS = 8'b1000_0000;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    prod_sense = 1'b0;
    coin_sense = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One request. dp/dc: cycles from stage start until the bench raises the
  // stage's sensor (-1 = never). Observation n is sampled after edge n, where
  // edge 0 is the accept edge. A sensor raised at observation k yields a
  // strobe in observation k+2, acted on at edge k+3.
  task automatic run_txn(input string name, input logic vend, input logic [1:0] chg,
                         input int dp, input int dc, input bit noise);
    int kind[3];
    int start[3];
    int dly[3];
    int n_st, n_started, s, t, done_obs, fault_obs, last;
    bit stopped;
    logic [1:0] ce, fc_model, fc;
    logic rdy, pd, c5, c10, dn, ft;
    logic [7:0] exp_o, got;

    ce = (chg == 2'd3) ? 2'd0 : chg;
    n_st = 0;
    if (vend) begin kind[n_st] = 0; dly[n_st] = dp; n_st++; end
    if (ce == 2'd1 || ce == 2'd2) begin kind[n_st] = int'(ce); dly[n_st] = dc; n_st++; end

    s = 0; done_obs = -1; fault_obs = -1; fc_model = 2'd0; stopped = 0; n_started = 0;
    for (int i = 0; i < n_st; i++) begin
      if (!stopped) begin
        start[i] = s;
        n_started++;
        t = s + dly[i] + 2;
        if (dly[i] >= 0 && t <= s + P - 1)      s = s + P;
        else if (dly[i] >= 0 && t <= s + T - 1) s = t + 1;
        else begin
          fault_obs = s + T;
          fc_model = (kind[i] == 0) ? 2'd1 : 2'd2;
          stopped = 1;
        end
      end
    end
    if (fault_obs < 0) done_obs = s;
    last = (fault_obs < 0) ? done_obs + 1 : fault_obs + 2;

    req_valid = 1'b1;
    req_vend = vend;
    req_change = chg;
    step();
    req_valid = 1'b0;

    for (int n = 0; n <= last; n++) begin
      pd = 0; c5 = 0; c10 = 0;
      for (int i = 0; i < n_started; i++) begin
        if (n >= start[i] && n < start[i] + P) begin
          if (kind[i] == 0) pd = 1;
          else if (kind[i] == 1) c5 = 1;
          else c10 = 1;
        end
      end
      dn  = (n == done_obs);
      rdy = (done_obs >= 0) && (n > done_obs);
      ft  = (fault_obs >= 0) && (n >= fault_obs);
      fc  = ft ? fc_model : 2'd0;
      exp_o = {rdy, pd, c5, c10, dn, ft, fc};
      got = outs();
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("[TB] FAIL %s obs=%0d outputs got %b want %b", name, n, got, exp_o);
      end

      for (int i = 0; i < n_started; i++) begin
        if (dly[i] >= 0 && n == start[i] + dly[i]) begin
          if (kind[i] == 0) prod_sense = 1'b1; else coin_sense = 1'b1;
        end
        if (dly[i] >= 0 && n == start[i] + dly[i] + 3) begin
          if (kind[i] == 0) prod_sense = 1'b0; else coin_sense = 1'b0;
        end
      end

      if (noise && (fault_obs >= 0 || n <= done_obs)) begin
        req_valid = 1'($urandom_range(0, 1));
        req_vend = 1'($urandom_range(0, 1));
        req_change = 2'($urandom_range(0, 3));
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    prod_sense = 1'b0;
    coin_sense = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_vend = 1'b0;
    req_change = 2'd0;
    prod_sense = 1'b0;
    coin_sense = 1'b0;
    step();
    step();
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++;
      $display("[TB] FAIL reset_state got %b want %b", outs(), IDLE_OUTS);
    end
    rst = 1'b0;
    step();
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++;
      $display("[TB] FAIL reset_release got %b want %b", outs(), IDLE_OUTS);
    end
  endtask

  task automatic test_vend_only();
    run_txn("vend_wait", 1'b1, 2'd0, 4, -1, 1'b0);
    run_txn("vend_fast", 1'b1, 2'd0, 0, -1, 1'b0);
    run_txn("vend_last_pulse", 1'b1, 2'd3, 1, -1, 1'b0);
  endtask

  task automatic test_vend_coin();
    run_txn("vend_coin10", 1'b1, 2'd2, 1, 1, 1'b0);
    run_txn("vend_coin5_slow", 1'b1, 2'd1, 7, 10, 1'b0);
  endtask

  task automatic test_refund();
    run_txn("refund5", 1'b0, 2'd1, -1, 0, 1'b0);
    run_txn("nothing", 1'b0, 2'd0, -1, -1, 1'b0);
    run_txn("reserved_chg", 1'b0, 2'd3, -1, -1, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("prod_timeout", 1'b1, 2'd2, -1, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_vend = 1'b1;
      req_change = 2'd1;
      step();
      checks++;
      if (outs() !== 8'b0000_0101) begin
        failures++;
        $display("[TB] FAIL fault_sticky got %b want %b", outs(), 8'b0000_0101);
      end
    end
    do_reset();
    step();
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++;
      $display("[TB] FAIL fault_clear got %b want %b", outs(), IDLE_OUTS);
    end
    run_txn("coin_timeout", 1'b0, 2'd1, -1, -1, 1'b0);
    do_reset();
  endtask

  task automatic test_coincide_busy();
    run_txn("coin_edge_at_timeout", 1'b0, 2'd2, -1, T - 3, 1'b0);
    run_txn("busy_drop", 1'b1, 2'd1, 3, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      coin_sense = 1'($urandom_range(0, 1));
      prod_sense = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (outs() !== IDLE_OUTS) begin
        failures++;
        $display("[TB] FAIL idle_edge got %b want %b", outs(), IDLE_OUTS);
      end
    end
    coin_sense = 1'b0;
    prod_sense = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_rst_abort();
    req_valid = 1'b1;
    req_vend = 1'b0;
    req_change = 2'd2;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++;
      $display("[TB] FAIL rst_abort got %b want %b", outs(), IDLE_OUTS);
    end
    rst = 1'b0;
    step();
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++;
      $display("[TB] FAIL rst_abort_idle got %b want %b", outs(), IDLE_OUTS);
    end
    run_txn("after_abort", 1'b1, 2'd2, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      run_txn("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, T - 3)), int'($urandom_range(0, T - 3)),
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_vend_only();
    test_vend_coin();
    test_refund();
    test_timeout();
    test_coincide_busy();
    test_rst_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
